// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gray_pkg
// Brief    : Shared width limits, FSM encoding and binary-to-Gray helper.
// Revision : 1.0
// ============================================================================
package gray_pkg;

    localparam int GRAY_W_MIN = 2;
    localparam int GRAY_W_MAX = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gray_cnt_state_t;

    function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_gray.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_gray
// Brief    : Combinational W-bit binary-to-Gray mapping of the next count.
// Revision : 1.0
// ============================================================================
module bin_to_gray
    import gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    // Widen into the helper's fixed width, then keep only the low W bits.
    assign gray = W'(bin2gray(GRAY_W_MAX'(bin)));

endmodule
`default_nettype wire

// File: rtl/gray_cnt_gen.sv
`default_nettype none
// ============================================================================
// Module   : gray_cnt_gen
// Brief    : Up/down Gray-code generator with load, terminal-count flag and a
//            registered valid/ready output. GRAY_CNT_WRAP_EN selects wrap at
//            the terminal code; otherwise the count saturates there.
// Revision : 1.0
// ============================================================================
module gray_cnt_gen
    import gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] gray_out,
    output logic         tc
);

    generate
        if (W < GRAY_W_MIN || W > GRAY_W_MAX) begin : g_w_range_bad
            $error("gray_cnt_gen: W out of range");
        end
    endgenerate

    gray_cnt_state_t state_q, state_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]    gray_q, gray_d;
    logic            tc_q, tc_d;
    logic [W-1:0]    cnt_step;
    logic            xfer;

    function automatic logic is_term(input logic [W-1:0] c, input logic up);
        return up ? (c == '1) : (c == '0);
    endfunction

    assign xfer = (state_q == RUN) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gray_q  <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gray_q  <= gray_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!load && en) state_d = RUN;
            RUN:     if (xfer && !en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
`ifdef GRAY_CNT_WRAP_EN
        cnt_step = up_dn ? cnt_q + W'(1) : cnt_q - W'(1);
`else
        if (is_term(cnt_q, up_dn)) begin
            cnt_step = cnt_q;
        end else begin
            cnt_step = up_dn ? cnt_q + W'(1) : cnt_q - W'(1);
        end
`endif
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && load) begin
            cnt_d = load_val;
        end else if (xfer) begin
            cnt_d = cnt_step;
        end
        // tc follows the current up_dn so a direction change shows next cycle.
        tc_d = (state_d == RUN) && is_term(cnt_d, up_dn);
    end

    bin_to_gray #(
        .W (W)
    ) u_bin_to_gray (
        .bin  (cnt_d),
        .gray (gray_d)
    );

    always_comb begin
        out_valid = (state_q == RUN);
        gray_out  = gray_q;
        tc        = tc_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_cnt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_cnt_gen
// Brief    : Scoreboard bench for gray_cnt_gen: directed scenarios then random.
// Revision : 1.0
// ============================================================================
module tb_gray_cnt_gen;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst, en, up_dn, load, out_ready;
    logic [W-1:0] load_val;
    logic         out_valid;
    logic [W-1:0] gray_out;
    logic         tc;

    always #5 clk = ~clk;

    gray_cnt_gen #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .gray_out  (gray_out),
        .tc        (tc)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: which count is on offer, and whether one is.
    int           exp_q[$];
    int           mdl_cnt    = 0;
    bit           mdl_run    = 1'b0;
    bit           mdl_updn   = 1'b1;
    bit           just_reset = 1'b0;
    bit           chain      = 1'b0;
    int           last_cnt   = 0;
    logic [W-1:0] last_gray  = '0;

    function automatic logic [W-1:0] gray_of(input int v);
        return W'(v ^ (v / 2));
    endfunction

    function automatic bit term_of(input int v, input bit up);
        return up ? (v == MAX) : (v == 0);
    endfunction

    function automatic int next_cnt(input int v, input bit up);
`ifdef GRAY_CNT_WRAP_EN
        if (up) return (v + 1) % (MAX + 1);
        return (v + MAX) % (MAX + 1);
`else
        if (up) return (v == MAX) ? v : v + 1;
        return (v == 0) ? v : v - 1;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Hold one set of inputs across a rising edge and advance the model.
    task automatic step(input bit r, input bit e, input bit u, input bit l,
                        input int lv, input bit rd);
        rst = r; en = e; up_dn = u; load = l; load_val = W'(lv); out_ready = rd;
        @(posedge clk);
        mdl_updn = u;
        if (r) begin
            mdl_run = 1'b0; mdl_cnt = 0; exp_q.delete(); just_reset = 1'b1; chain = 1'b0;
        end else begin
            just_reset = 1'b0;
            if (!mdl_run) begin
                if (l) begin
                    mdl_cnt = lv & MAX; chain = 1'b0;
                end else if (e) begin
                    mdl_run = 1'b1; exp_q.push_back(mdl_cnt);
                end
            end else if (rd) begin
                mdl_cnt = next_cnt(mdl_cnt, u);
                if (e) exp_q.push_back(mdl_cnt);
                else   mdl_run = 1'b0;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        int c;
        check("out_valid", 32'(out_valid), 32'(mdl_run));
        if (just_reset) begin
            check("rst_gray", 32'(gray_out), 32'd0);
            check("rst_tc", 32'(tc), 32'd0);
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty actual=valid required=no_offer at %0t", $time);
            end else begin
                c = exp_q[0];
                check("gray_out", 32'(gray_out), 32'(gray_of(c)));
                check("tc", 32'(tc), 32'(term_of(c, mdl_updn)));
                if (out_ready && !rst) begin
                    void'(exp_q.pop_front());
                    if (chain)
                        check("one_bit_step", 32'($countones(last_gray ^ gray_out)),
                              (c == last_cnt) ? 32'd0 : 32'd1);
                    chain     = 1'b1;
                    last_cnt  = c;
                    last_gray = gray_out;
                end
            end
        end
    end

    initial begin
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        // Free-run up through the terminal code and beyond.
        for (int i = 0; i < 19; i++) step(0, 1, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        // Backpressure while offering 0011.
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, i[0], 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        // Load 5, count down, then reset mid-run.
        step(0, 0, 0, 1, 5, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        // Saturation (or wrap) at the top, then reverse direction.
        step(0, 0, 1, 1, 15, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 0);
        // Load ignored in RUN, en drop returns to IDLE, re-enable resumes.
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 1, 9, 0);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        // Random traffic; direction changes rarely so terminals are reached.
        begin
            bit u = 1'b1;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 7) == 0) u = ~u;
                step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, u,
                     $urandom_range(0, 7) == 0, int'($urandom_range(0, MAX)),
                     $urandom_range(0, 2) != 0);
            end
        end
        step(0, 0, 1, 0, 0, 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_cnt_gen.md
# gray_cnt_gen

Parameterised Gray-code sequence generator that sits directly upstream of the 4-bit Gray-to-binary converter. It keeps a binary count internally and presents a registered, glitch-free Gray code on a valid/ready output. It also supports up/down stepping, a parallel load and a terminal-count flag. The converter and downstream logic consume the codes one per accepted transfer.

## Interface
- `W`, default 4: code width; legal range 2..16.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run request; starts presentation and permits continued stepping.
- `up_dn`  in  1  step direction, sampled on a transfer: 1 = increment, 0 = decrement.
- `load`  in  1  parallel-load strobe; honoured in IDLE only.
- `load_val`  in  W  binary value to load.
- `out_ready`  in  1  downstream accepts `gray_out` this cycle.
- `out_valid`  out  1  `gray_out` holds a code being offered.
- `gray_out`  out  W  registered Gray code of the internal count.
- `tc`  out  1  the offered code is terminal for the current `up_dn`: binary all-ones when counting up, zero when counting down.

## Operation
- State is binary count `cnt[W-1:0]` plus a two-state FSM.
- Gray mapping is fixed: `gray = cnt ^ (cnt >> 1)`.
- A transfer occurs when `out_valid && out_ready`.
- **IDLE** (`out_valid` = 0):
  - `load` = 1 → `cnt <= load_val`; stay in IDLE.
  - Otherwise `en` = 1 → go to RUN, presenting `gray(cnt)`.
  - `load` and `en` in the same cycle: load wins; RUN is entered on a later cycle.
- **RUN** (`out_valid` = 1):
  - No transfer → `gray_out` and `tc` hold stable. `load` is ignored, and `en` falling does not drop `out_valid`.
  - Transfer → `cnt` steps ±1 per the sampled `up_dn`. If `en` = 1, stay in RUN and present the new code; if `en` = 0, go to IDLE holding the stepped count.
- Arithmetic is modulo 2^W. Wrap behaviour is set by the configuration macro.
- Consecutive presented codes differ in exactly one bit, including across the wrap.
- `tc` is registered alongside `gray_out`. It depends on the presented count and the current `up_dn`, so it updates the cycle after `up_dn` changes.

## Timing
- Reset values: FSM = IDLE, `cnt` = 0, `gray_out` = 0, `out_valid` = 0, `tc` = 0.
- `en` high in IDLE at edge n → `out_valid` = 1 at n+1 with `gray_out` = `gray(cnt)`.
- Transfer at edge n → next code on `gray_out` at n+1. Throughput is one code per cycle while `out_ready` and `en` are held high.
- Load at edge n → `cnt` updated at n+1; it is presented no earlier than n+2.
- `rst` during RUN: at the next edge all outputs return to their reset values, with no partial transfer.
- `rst` has priority over `load`, `en` and a transfer in the same cycle.

## Configuration
- **`GRAY_CNT_WRAP_EN` defined:** a transfer on a terminal code wraps the count (max → 0 up, 0 → max down). `tc` pulses with that code.
- **`GRAY_CNT_WRAP_EN` not defined:** a transfer on a terminal code leaves `cnt` unchanged, so the same code is re-offered and `tc` stays high. Stepping in the other direction clears `tc` and resumes.

## Structure
- Package `gray_pkg` holds:
  - function `bin2gray(bin)`;
  - localparams `GRAY_W_MIN` = 2 and `GRAY_W_MAX` = 16;
  - FSM enum `gray_cnt_state_t` {IDLE, RUN}.
- One sub-module, `bin_to_gray`: a combinational W-bit mapping from next-count to next-Gray, feeding the output register.
- The counter, FSM and output registers live in `gray_cnt_gen`.

## Test plan
- **Reset, then free-run up:** `rst` 1→0, `en` = 1, `up_dn` = 1, `out_ready` = 1, W = 4 → one cycle after `en`, codes 0000, 0001, 0011, 0010, 0110, … 1000 (`tc` = 1), then 0000 with the macro defined. Every pair of consecutive codes differs in exactly one bit.
- **Backpressure:** in RUN offering 0011, drop `out_ready` for 3 cycles with `en` toggling → `gray_out` holds 0011 and `out_valid` holds 1. Raising `out_ready` yields 0010 on the next cycle.
- **Load and count down:** in IDLE, `load` = 1, `load_val` = 5 → `en` = 1 presents 0111. Transfer with `up_dn` = 0 → 0110 (binary 4).
- **Saturation without the macro:** load 15, count up → 1000 with `tc` = 1, re-offered on every transfer. Switching to `up_dn` = 0 → `tc` clears after one cycle, and the next transfer gives 1001 (binary 14).
- **Load ignored in RUN and `en` drop:** in RUN offering 0001, `load` = 1 with `load_val` = 9 and no transfer → 0001 held. Transfer with `en` = 0 → IDLE, `out_valid` = 0. Re-enable → 0011.
- **Reset mid-run:** assert `rst` while offering 0110 with `out_ready` = 1 → next cycle `out_valid` = 0, `gray_out` = 0000, `tc` = 0.
